// File: rtl/dvi_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dvi_tx_pkg
// Brief    : Shared constants, stage-1 payload type and helpers for TMDS encode
// Revision : 1.0
// ============================================================================
package dvi_tx_pkg;

  localparam int DEF_CNT_W = 6;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  typedef struct packed {
    logic       de;
    logic [1:0] c;
    logic [8:0] qm;
  } tmds_s1_t;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + {3'b000, v[i]};
    end
    return s;
  endfunction

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvi_tx_encoder_tmds_channel_enc.sv
`default_nettype none
// ============================================================================
// Module   : tmds_channel_enc
// Brief    : One TMDS 8b/10b channel: transition-minimise stage, then DC balance
// Revision : 1.0
// ============================================================================
module tmds_channel_enc
  import dvi_tx_pkg::*;
#(
  parameter int CNT_W = dvi_tx_pkg::DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de,
  input  logic [1:0] c,
  input  logic [7:0] d,
  output logic [9:0] q
);

  logic [3:0] w_n1d;
  logic       w_xnor;
  logic [8:0] w_qm;
  tmds_s1_t   r_s1;

  always_comb begin
    w_n1d   = ones8(d);
    w_xnor  = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !d[0]);
    w_qm    = '0;
    w_qm[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ d[i]) : (w_qm[i-1] ^ d[i]);
    end
    w_qm[8] = ~w_xnor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
    end else begin
      r_s1 <= '{de: de, c: c, qm: w_qm};
    end
  end

  logic        [3:0]       w_n1;
  logic signed [CNT_W-1:0] w_diff;
  logic signed [CNT_W-1:0] w_two;
  logic signed [CNT_W-1:0] r_cnt;
  logic signed [CNT_W-1:0] w_cnt_nxt;
  logic        [9:0]       r_q;
  logic        [9:0]       w_q_nxt;
  logic                    w_cnt_pos;
  logic                    w_cnt_neg;

  // w_diff is n1 - n0 = 2*n1 - 8 for the 8 payload bits
  always_comb begin
    w_n1      = ones8(r_s1.qm[7:0]);
    w_diff    = (CNT_W'(w_n1) <<< 1) - CNT_W'(8);
    w_two     = r_s1.qm[8] ? CNT_W'(2) : CNT_W'(0);
    w_cnt_neg = r_cnt[CNT_W-1];
    w_cnt_pos = !r_cnt[CNT_W-1] && (r_cnt != '0);
    w_q_nxt   = CTRL_00;
    w_cnt_nxt = r_cnt;
    if (!r_s1.de) begin
      w_q_nxt   = ctrl_code(r_s1.c);
      w_cnt_nxt = '0;
    end else if ((r_cnt == '0) || (w_n1 == 4'd4)) begin
      w_q_nxt   = {~r_s1.qm[8], r_s1.qm[8],
                   r_s1.qm[8] ? r_s1.qm[7:0] : ~r_s1.qm[7:0]};
      w_cnt_nxt = r_s1.qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
    end else if ((w_cnt_pos && (w_n1 > 4'd4)) || (w_cnt_neg && (w_n1 < 4'd4))) begin
      w_q_nxt   = {1'b1, r_s1.qm[8], ~r_s1.qm[7:0]};
      w_cnt_nxt = r_cnt + w_two - w_diff;
    end else begin
      w_q_nxt   = {1'b0, r_s1.qm[8], r_s1.qm[7:0]};
      w_cnt_nxt = r_cnt + w_diff - (CNT_W'(2) - w_two);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= CTRL_00;
      r_cnt <= '0;
    end else begin
      r_q   <= w_q_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/dvi_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : dvi_tx_encoder
// Brief    : Three-channel DVI TMDS encoder; maps RGB and sync onto channels
// Revision : 1.0
// ============================================================================
module dvi_tx_encoder
  import dvi_tx_pkg::*;
#(
  parameter int CNT_W = dvi_tx_pkg::DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2
);

  tmds_channel_enc #(.CNT_W(CNT_W)) u_ch0 (
    .clk   (clk),
    .rst_n (rst_n),
    .de    (de),
    .c     ({vsync, hsync}),
    .d     (b),
    .q     (tmds_ch0)
  );

  tmds_channel_enc #(.CNT_W(CNT_W)) u_ch1 (
    .clk   (clk),
    .rst_n (rst_n),
    .de    (de),
    .c     (2'b00),
    .d     (g),
    .q     (tmds_ch1)
  );

  tmds_channel_enc #(.CNT_W(CNT_W)) u_ch2 (
    .clk   (clk),
    .rst_n (rst_n),
    .de    (de),
    .c     (2'b00),
    .d     (r),
    .q     (tmds_ch2)
  );

endmodule
`default_nettype wire
